// File: rtl/fwd_clr_pipe_n.sv
// DEPTH-stage valid/ready register pipe with bubble collapse, optional input skid and sync clear.
// Latency DEPTH cycles; ready ripples from b_ready_in (SKID_EN=0) or is a register (SKID_EN=1).
module fwd_clr_pipe_n #(
    parameter int DATA_W   = 256,
    parameter int DEPTH    = 2,
    parameter bit SKID_EN  = 1'b0,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              f_valid_in,
    input  logic [DATA_W-1:0] f_data_in,
    output logic              f_ready_out,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    input  logic              b_ready_in,
    output logic [CNT_W-1:0]  occ_cnt,
    output logic              empty
);

    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  in_v;
    logic [DATA_W-1:0] in_d [DEPTH];
    logic              fe_v;
    logic [DATA_W-1:0] fe_d;
    logic              up_xfer;
    logic              dn_xfer;

    // Stage i can move when any stage from i to the output has a hole, or the sink takes a beat.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            rdy[i]   = ~all_full | b_ready_in;
        end
    end

    always_comb begin
        in_v    = '0;
        in_v[0] = fe_v;
        in_d[0] = fe_d;
        for (int i = 1; i < DEPTH; i++) begin
            in_v[i] = v[i-1];
            in_d[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (clr) begin
            v <= '0;
            if (CLR_DATA) begin
                for (int i = 0; i < DEPTH; i++) d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= in_v[i];
                    if (in_v[i]) d[i] <= in_d[i];
                end
            end
        end
    end

    if (SKID_EN) begin : g_skid
        logic              skid_valid;
        logic [DATA_W-1:0] skid_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (clr) begin
                skid_valid <= 1'b0;
                if (CLR_DATA) skid_data <= '0;
            end else if (f_valid_in & ~skid_valid & ~rdy[0]) begin
                skid_valid <= 1'b1;
                skid_data  <= f_data_in;
            end else if (skid_valid & rdy[0]) begin
                skid_valid <= 1'b0;
            end
        end

        // A held skid beat always goes first so ordering is preserved.
        assign fe_v        = skid_valid | f_valid_in;
        assign fe_d        = skid_valid ? skid_data : f_data_in;
        assign f_ready_out = ~skid_valid;
    end else begin : g_noskid
        assign fe_v        = f_valid_in;
        assign fe_d        = f_data_in;
        assign f_ready_out = rdy[0];
    end

    assign up_xfer = f_valid_in & f_ready_out;
    assign dn_xfer = b_valid_out & b_ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_cnt <= '0;
        end else if (clr) begin
            occ_cnt <= '0;
        end else if (up_xfer & ~dn_xfer) begin
            occ_cnt <= occ_cnt + CNT_W'(1);
        end else if (~up_xfer & dn_xfer) begin
            occ_cnt <= occ_cnt - CNT_W'(1);
        end
    end

    assign b_valid_out = v[DEPTH-1];
    assign b_data_out  = d[DEPTH-1];
    assign empty       = (occ_cnt == '0);

endmodule

// File: tb/tb_fwd_clr_pipe_n.sv
// Directed and randomized checks of fwd_clr_pipe_n across four configurations.
module tb_fwd_clr_pipe_n;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a: DEPTH=2 no skid, b: DEPTH=3 no skid, c: DEPTH=2 skid, d: DEPTH=4 skid
    logic a_clr, a_fv, a_fr, a_bv, a_br, a_em;
    logic [W-1:0] a_fd, a_bd;
    logic [1:0] a_oc;
    logic b_clr, b_fv, b_fr, b_bv, b_br, b_em;
    logic [W-1:0] b_fd, b_bd;
    logic [2:0] b_oc;
    logic c_clr, c_fv, c_fr, c_bv, c_br, c_em;
    logic [W-1:0] c_fd, c_bd;
    logic [1:0] c_oc;
    logic d_clr, d_fv, d_fr, d_bv, d_br, d_em;
    logic [W-1:0] d_fd, d_bd;
    logic [2:0] d_oc;

    fwd_clr_pipe_n #(.DATA_W(W), .DEPTH(2), .SKID_EN(1'b0), .CLR_DATA(1'b1)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .f_valid_in(a_fv), .f_data_in(a_fd),
        .f_ready_out(a_fr), .b_valid_out(a_bv), .b_data_out(a_bd), .b_ready_in(a_br),
        .occ_cnt(a_oc), .empty(a_em));
    fwd_clr_pipe_n #(.DATA_W(W), .DEPTH(3), .SKID_EN(1'b0), .CLR_DATA(1'b1)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .f_valid_in(b_fv), .f_data_in(b_fd),
        .f_ready_out(b_fr), .b_valid_out(b_bv), .b_data_out(b_bd), .b_ready_in(b_br),
        .occ_cnt(b_oc), .empty(b_em));
    fwd_clr_pipe_n #(.DATA_W(W), .DEPTH(2), .SKID_EN(1'b1), .CLR_DATA(1'b1)) u_c (
        .clk(clk), .rst(rst), .clr(c_clr), .f_valid_in(c_fv), .f_data_in(c_fd),
        .f_ready_out(c_fr), .b_valid_out(c_bv), .b_data_out(c_bd), .b_ready_in(c_br),
        .occ_cnt(c_oc), .empty(c_em));
    fwd_clr_pipe_n #(.DATA_W(W), .DEPTH(4), .SKID_EN(1'b1), .CLR_DATA(1'b1)) u_d (
        .clk(clk), .rst(rst), .clr(d_clr), .f_valid_in(d_fv), .f_data_in(d_fd),
        .f_ready_out(d_fr), .b_valid_out(d_bv), .b_data_out(d_bd), .b_ready_in(d_br),
        .occ_cnt(d_oc), .empty(d_em));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q[$];

    initial begin
        rst = 1'b1;
        {a_clr, a_fv, a_br, a_fd} = '0;
        {b_clr, b_fv, b_br, b_fd} = '0;
        {c_clr, c_fv, c_br, c_fd} = '0;
        {d_clr, d_fv, d_br, d_fd} = '0;
        #1;
        chk("rst_a_rdy", a_fr, 1);
        chk("rst_a_vld", a_bv, 0);
        chk("rst_a_dat", a_bd, 0);
        chk("rst_a_occ", a_oc, 0);
        chk("rst_a_empty", a_em, 1);
        chk("rst_c_rdy", c_fr, 1);
        chk("rst_d_empty", d_em, 1);
        #1 rst = 1'b0;
        tick();

        // streaming through DEPTH=2
        a_br = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            a_fv = (k <= 8);
            a_fd = W'(k);
            #1;
            chk("a_stream_rdy", a_fr, 1);
            chk("a_stream_vld", a_bv, (k >= 3));
            if (k >= 3) chk("a_stream_dat", a_bd, k - 2);
            chk("a_stream_occ", a_oc, (k == 1) ? 0 : ((k == 2 || k == 10) ? 1 : 2));
            tick();
        end
        a_fv = 1'b0;
        #1;
        chk("a_drain_empty", a_em, 1);
        chk("a_drain_vld", a_bv, 0);

        // bubble collapse with DEPTH=3 under stall
        b_br = 1'b0;
        b_fv = 1'b1; b_fd = 16'h000A; #1; chk("b_rdy_a", b_fr, 1); tick();
        b_fv = 1'b0;                  #1; chk("b_rdy_idle", b_fr, 1); tick();
        b_fv = 1'b1; b_fd = 16'h000B; #1; chk("b_rdy_b", b_fr, 1); tick();
        b_fv = 1'b0; #1;
        chk("b_occ2", b_oc, 2);
        chk("b_head_vld", b_bv, 1);
        chk("b_head_dat", b_bd, 16'h000A);
        tick();
        b_fv = 1'b1; b_fd = 16'h000C; #1; chk("b_rdy_c", b_fr, 1); tick();
        b_fv = 1'b0; #1;
        chk("b_full_rdy", b_fr, 0);
        chk("b_full_occ", b_oc, 3);
        b_br = 1'b1; #1;
        chk("b_out_a", b_bd, 16'h000A);
        chk("b_out_a_vld", b_bv, 1);
        tick();
        chk("b_out_b", b_bd, 16'h000B);
        chk("b_out_b_vld", b_bv, 1);
        tick();
        chk("b_out_c", b_bd, 16'h000C);
        chk("b_out_c_vld", b_bv, 1);
        tick();
        chk("b_empty", b_em, 1);

        // skid entry with DEPTH=2
        c_br = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            c_fv = 1'b1; c_fd = W'(k); #1;
            chk("c_fill_rdy", c_fr, 1);
            tick();
        end
        c_fv = 1'b0; #1;
        chk("c_full_rdy", c_fr, 0);
        chk("c_full_occ", c_oc, 3);
        c_br = 1'b1; #1;
        chk("c_out1_vld", c_bv, 1);
        chk("c_out1", c_bd, 1);
        tick();
        chk("c_rdy_back", c_fr, 1);
        chk("c_out2", c_bd, 2);
        chk("c_occ2", c_oc, 2);
        tick();
        chk("c_out3", c_bd, 3);
        chk("c_occ1", c_oc, 1);
        tick();
        chk("c_empty", c_em, 1);

        // synchronous clear with a same-cycle upstream beat
        a_br = 1'b0;
        a_fv = 1'b1; a_fd = 16'h00AA; tick();
        a_fd = 16'h00BB; tick();
        a_fv = 1'b0; #1;
        chk("a_preclr_dat", a_bd, 16'h00AA);
        chk("a_preclr_occ", a_oc, 2);
        chk("a_preclr_rdy", a_fr, 0);
        a_clr = 1'b1; a_fv = 1'b1; a_fd = 16'h00CC; a_br = 1'b1;
        tick();
        a_clr = 1'b0; a_fv = 1'b0; #1;
        chk("a_clr_vld", a_bv, 0);
        chk("a_clr_dat", a_bd, 0);
        chk("a_clr_occ", a_oc, 0);
        chk("a_clr_empty", a_em, 1);
        tick();
        tick();
        chk("a_clr_no_cc", a_bv, 0);

        // asynchronous reset while the pipe is full
        a_br = 1'b0;
        a_fv = 1'b1; a_fd = 16'h0011; tick();
        a_fd = 16'h0022; tick();
        a_fv = 1'b0; #1;
        chk("a_prerst_occ", a_oc, 2);
        chk("a_prerst_vld", a_bv, 1);
        #2 rst = 1'b1;
        #1;
        chk("a_arst_vld", a_bv, 0);
        chk("a_arst_occ", a_oc, 0);
        chk("a_arst_rdy", a_fr, 1);
        #1 rst = 1'b0;
        tick();
        a_fv = 1'b1; a_fd = 16'h0055; a_br = 1'b1; #1;
        chk("a_post_vld0", a_bv, 0);
        tick();
        a_fv = 1'b0; #1;
        chk("a_post_vld1", a_bv, 0);
        tick();
        chk("a_post_vld2", a_bv, 1);
        chk("a_post_dat", a_bd, 16'h0055);

        // randomized traffic on DEPTH=4 with skid, against an in-order queue model
        for (int n = 0; n < 10000; n++) begin
            d_fv  = ($urandom % 4) != 0;
            d_br  = ($urandom % 3) != 0;
            d_clr = ($urandom % 64) == 0;
            d_fd  = W'($urandom);
            #1;
            chk("d_occ", d_oc, q.size());
            if (d_bv && d_br) begin
                if (q.size() == 0) chk("d_spurious", d_bv, 0);
                else chk("d_data", d_bd, q.pop_front());
            end
            if (d_clr) q.delete();
            else if (d_fv && d_fr) q.push_back(d_fd);
            tick();
        end
        d_fv = 1'b0; d_clr = 1'b0; d_br = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (d_bv) begin
                if (q.size() == 0) chk("d_drain_spurious", d_bv, 0);
                else chk("d_drain_data", d_bd, q.pop_front());
            end
            tick();
        end
        chk("d_drain_empty", d_em, 1);
        chk("d_drain_lost", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_clr_pipe_n.md
Name: fwd_clr_pipe_n

Overview:
- Parametrised DEPTH-stage forward valid/ready register pipeline with synchronous clear; the next generation of the single-stage forward pipe.
- Adds bubble collapsing, so an empty stage accepts data even while downstream stalls.
- Adds an occupancy count and an optional input skid entry that makes f_ready_out a pure register output.
- Inserted on long datapath routes (DMA, NoC, PE-array feeds) to cut timing paths without throughput loss.

Parameters:
- DATA_W, 256, payload width in bits.
- DEPTH, 2, number of data register stages (1..16).
- SKID_EN, 0, 1 adds one skid entry at the input so f_ready_out is registered.
- CLR_DATA, 1, 1 zeroes all data registers on clr; 0 clears valids only.
- CNT_W, $clog2(DEPTH+2), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous flush, highest priority after rst.
- f_valid_in  in  1  upstream valid.
- f_data_in  in  DATA_W  upstream payload.
- f_ready_out  out  1  upstream ready.
- b_valid_out  out  1  downstream valid (stage DEPTH-1 valid).
- b_data_out  out  DATA_W  downstream payload (stage DEPTH-1 data).
- b_ready_in  in  1  downstream ready.
- occ_cnt  out  CNT_W  number of valid entries held (stages plus skid).
- empty  out  1  occ_cnt==0.

Behaviour:
- Reset (rst=1, async): all stage valids=0, data=0, skid_valid=0, occ_cnt=0. Outputs: b_valid_out=0, b_data_out=0, empty=1. f_ready_out=1 (both modes).
- Stages are indexed 0 (input side) to DEPTH-1 (output side). v[i] and d[i] are per-stage registers.
- Ready chain (combinational):
  - rdy[DEPTH]=b_ready_in.
  - rdy[i]=~v[i] | rdy[i+1].
- Stage input: in_v[0]/in_d[0] come from the front end; in_v[i]=v[i-1] and in_d[i]=d[i-1] for i>0.
- Stage update when rdy[i]=1:
  - v[i]<=in_v[i].
  - d[i]<=in_d[i] only if in_v[i]=1; otherwise d[i] holds.
- When rdy[i]=0, stage i holds.
- Transfers:
  - Upstream transfer = f_valid_in & f_ready_out.
  - Downstream transfer = b_valid_out & b_ready_in.
  - Data is never duplicated or dropped.
- SKID_EN=0:
  - Front end is f_valid_in/f_data_in.
  - f_ready_out=rdy[0], combinational from b_ready_in.
  - Latency DEPTH cycles into an empty pipe. Throughput 1 beat/cycle.
- SKID_EN=1:
  - f_ready_out=~skid_valid (register output).
  - Front end is the skid entry when skid_valid=1, else f_valid_in/f_data_in.
  - Capture: when f_valid_in & ~skid_valid & ~rdy[0], set skid_valid<=1 and skid_data<=f_data_in.
  - Release: when skid_valid & rdy[0], skid data enters stage 0 and skid_valid<=0.
  - Latency DEPTH cycles when unstalled. Throughput 1 beat/cycle.
- occ_cnt:
  - Registered, updated +1 on upstream transfer, -1 on downstream transfer, unchanged when both or neither occur.
  - Always equals popcount(v)+skid_valid.
  - Maximum value is DEPTH+SKID_EN.
- clr (synchronous):
  - All v[i]=0, skid_valid=0, occ_cnt=0 next cycle.
  - d[i] and skid_data zeroed when CLR_DATA=1.
  - A same-cycle upstream beat is discarded even if f_ready_out=1. The upstream beat is not retained.
  - A same-cycle downstream transfer still completes, because the output register is valid in that cycle.
- Simultaneous full pipe and b_ready_in=1: a beat exits and a beat enters in the same cycle; occ_cnt unchanged.
- Stall with gaps: bubbles are squeezed out. A pipe holding beats in non-adjacent stages compacts toward the output while b_ready_in=0.
- rst asserted mid-transfer: everything clears immediately (async); no output beat is produced for in-flight data.
- f_data_in is don't-care when f_valid_in=0. b_data_out holds its last value when b_valid_out=0.

Test Plan:
- Streaming, DEPTH=2, SKID_EN=0: f_valid_in=1 for 8 cycles with data 1..8, b_ready_in=1 -> b_valid_out rises on cycle 2 and data 1..8 appear back to back. occ_cnt steady at 2; empty=1 after drain.
- Backpressure with bubble collapse, DEPTH=3: inject A, idle, B, with b_ready_in=0 -> A in stage 2 and B in stage 1. f_ready_out stays 1 until occ_cnt=3. Release b_ready_in -> A then B in consecutive cycles.
- Skid, SKID_EN=1, DEPTH=2: fill with b_ready_in=0 and 3 beats -> f_ready_out=0 the cycle after the 3rd beat, occ_cnt=3. Raise b_ready_in -> beats exit in order and f_ready_out=1 one cycle after the skid releases.
- Clear: pipe holds 0xAA and 0xBB, assert clr with f_valid_in=1 data 0xCC -> next cycle b_valid_out=0, b_data_out=0 (CLR_DATA=1), occ_cnt=0, and 0xCC never appears at the output.
- Async reset mid-stream: assert rst between clock edges while the pipe is full -> b_valid_out=0, occ_cnt=0, f_ready_out=1 immediately without a clock edge. Resume traffic -> first output is the first post-reset beat.
- Random valid/ready, DEPTH=4, SKID_EN=1, 10k cycles -> scoreboard shows in-order data with no loss or duplication, and occ_cnt always equals the number in flight.
